axil_regfile_slave: RTL

//  Parametrised AXI4-Lite slave register file. Supersedes the fixed 4x32 slave.

---
 rtl/axil_regfile_slave_if.sv | 37 +++
 rtl/axil_regfile_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle used by axil_regfile_slave.
// Carries the five AXI-Lite channels: AW (AWADDR/AWVALID/AWREADY),
// W (WDATA/WSTRB/WVALID/WREADY), B (BRESP/BVALID/BREADY),
// AR (ARADDR/ARVALID/ARREADY) and R (RDATA/RRESP/RVALID/RREADY).
// The master modport drives requests; the slave modport drives responses.
interface axil_regfile_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_regfile_slave.sv
// Parametrised AXI4-Lite slave register file (generic control/status bank).
// Ports:
//   ACLK     - clock, all logic on the rising edge
//   ARESETn  - asynchronous active-low reset; clears every output and register
//   bus      - axil_regfile_slave_if.slave, the five AXI-Lite channels
// AW and W are accepted independently; the write commits and BVALID rises one
// edge after the later of the two handshakes. Reads return data one edge after
// the AR handshake. Out-of-range indices (>= NUM_REGS) never modify state and
// answer with an error response.
// Build option: define AXIL_SLV_DECERR_EN to answer out-of-range accesses with
// DECERR (2'b11); otherwise SLVERR (2'b10) is returned.
module axil_regfile_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axil_regfile_slave_if.slave  bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  // One extra bit so that NUM_REGS == 2**IDX_W does not wrap to zero.
  localparam logic [IDX_W:0] REG_LIMIT = (IDX_W+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] RESP_ERR = 2'b11;
`else
  localparam logic [1:0] RESP_ERR = 2'b10;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t              w_state_reg;
  logic                  aw_done_reg, w_done_reg;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]     wstrb_reg;
  logic                  awready_reg, wready_reg, bvalid_reg;
  logic [1:0]            bresp_reg;

  r_state_t              r_state_reg;
  logic                  ar_done_reg;
  logic [IDX_W-1:0]      ar_idx_reg;
  logic                  arready_reg, rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  logic [DATA_WIDTH-1:0] reg_words [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  w_commit;
  logic                  aw_in_range, ar_in_range;
  logic                  unused_addr_bits;

  assign aw_in_range = {1'b0, aw_idx_reg} < REG_LIMIT;
  assign ar_in_range = {1'b0, ar_idx_reg} < REG_LIMIT;
  assign w_commit    = (w_state_reg == W_IDLE) && aw_done_reg && w_done_reg;
  // Sub-word address bits carry no meaning for a word-wide register file.
  assign unused_addr_bits = &{1'b0, bus.AWADDR[LSB-1:0], bus.ARADDR[LSB-1:0]};

  // Write channel. READYs are re-armed in W_IDLE, which also raises them on
  // the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_reg <= W_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_done_reg && w_done_reg) begin
            bvalid_reg  <= 1'b1;
            bresp_reg   <= aw_in_range ? RESP_OKAY : RESP_ERR;
            w_state_reg <= W_RESP;
          end else begin
            if (!aw_done_reg) begin
              if (awready_reg && bus.AWVALID) begin
                aw_idx_reg  <= bus.AWADDR[ADDR_WIDTH-1:LSB];
                awready_reg <= 1'b0;
                aw_done_reg <= 1'b1;
              end else begin
                awready_reg <= 1'b1;
              end
            end
            if (!w_done_reg) begin
              if (wready_reg && bus.WVALID) begin
                wdata_reg  <= bus.WDATA;
                wstrb_reg  <= bus.WSTRB;
                wready_reg <= 1'b0;
                w_done_reg <= 1'b1;
              end else begin
                wready_reg <= 1'b1;
              end
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Register storage. Out-of-range indices match no entry, so they write nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] word_reg;
      logic                  wr_en;
      assign wr_en = w_commit && (aw_idx_reg == IDX_W'(gi));
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          word_reg <= '0;
        end else if (wr_en) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_reg[b]) word_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
          end
        end
      end
      assign reg_words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_reg == IDX_W'(i)) rd_word = reg_words[i];
    end
  end

  // Read channel. RDATA samples the registers before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_reg <= R_IDLE;
      ar_done_reg <= 1'b0;
      ar_idx_reg  <= '0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_done_reg) begin
            rdata_reg   <= ar_in_range ? rd_word : '0;
            rresp_reg   <= ar_in_range ? RESP_OKAY : RESP_ERR;
            rvalid_reg  <= 1'b1;
            r_state_reg <= R_RESP;
          end else if (arready_reg && bus.ARVALID) begin
            ar_idx_reg  <= bus.ARADDR[ADDR_WIDTH-1:LSB];
            arready_reg <= 1'b0;
            ar_done_reg <= 1'b1;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.RREADY) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            ar_done_reg <= 1'b0;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign bus.AWREADY = awready_reg;
  assign bus.WREADY  = wready_reg;
  assign bus.BVALID  = bvalid_reg;
  assign bus.BRESP   = bresp_reg;
  assign bus.ARREADY = arready_reg;
  assign bus.RVALID  = rvalid_reg;
  assign bus.RDATA   = rdata_reg;
  assign bus.RRESP   = rresp_reg;
endmodule
